// File: rtl/hazard_control_unit_pkg.sv
// Shared opcode constants and hazard FSM encodings for the pipeline control slice.
package hazard_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;

  // Encoding 2'd3 is unused and is decoded as IDLE by the FSM.
  typedef enum logic [1:0] {
    HZ_IDLE       = 2'd0,
    HZ_BR_WAIT    = 2'd1,
    HZ_BR_RESOLVE = 2'd2
  } hz_state_e;

  // True when the instruction reads rt as a source operand.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/hazard_control_unit_loaduse.sv
// Combinational load-use compare between the load in EX and the sources of ID.
module hazard_loaduse_detect
  import hazard_control_unit_pkg::*;
(
  input  logic       MemRead_EX,
  input  logic [4:0] Rt_EX,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic [5:0] Opcode_ID,
  output logic       LU
);

  logic rs_hit;
  logic rt_hit;

  // $0 is never a real dependency; rt only counts for opcodes that read it.
  always_comb begin
    rs_hit = (Rt_EX == Rs_ID);
    rt_hit = (Rt_EX == Rt_ID) && reads_rt(Opcode_ID);
    LU     = MemRead_EX && (Rt_EX != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control: load-use stall, BEQ serialisation until MEM resolve, J fetch flush.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int BRANCH_RESOLVE_STAGES = 2,
  parameter int STALL_CNT_W           = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [5:0]             Opcode_ID,
  input  logic [4:0]             Rs_ID,
  input  logic [4:0]             Rt_ID,
  input  logic                   MemRead_EX,
  input  logic [4:0]             Rt_EX,
  input  logic                   Branch_Taken_MEM,
  output logic                   PC_Write_En,
  output logic                   IF_ID_Write_En,
  output logic                   IF_ID_Flush,
  output logic                   ID_Control_NOP,
  output logic [1:0]             Hazard_State,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  localparam int CNT_W = $clog2(BRANCH_RESOLVE_STAGES) + 1;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (BRANCH_RESOLVE_STAGES >= 2) ? CNT_W'(BRANCH_RESOLVE_STAGES - 2) : '0;

  hz_state_e              state_q, state_d;
  logic [CNT_W-1:0]       wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   lu;

  hazard_loaduse_detect u_lu (
    .MemRead_EX (MemRead_EX),
    .Rt_EX      (Rt_EX),
    .Rs_ID      (Rs_ID),
    .Rt_ID      (Rt_ID),
    .Opcode_ID  (Opcode_ID),
    .LU         (lu)
  );

  // State, wait counter and stall counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= HZ_IDLE;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and output decode; reset forces the safe fetch-blocking outputs.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    PC_Write_En    = 1'b1;
    IF_ID_Write_En = 1'b1;
    IF_ID_Flush    = 1'b0;
    ID_Control_NOP = 1'b0;

    case (state_q)
      HZ_BR_WAIT: begin
        PC_Write_En    = 1'b0;
        IF_ID_Write_En = 1'b0;
        IF_ID_Flush    = 1'b1;
        ID_Control_NOP = 1'b1;
        if (wait_q == '0) state_d = HZ_BR_RESOLVE;
        else              wait_d  = wait_q - 1'b1;
      end
      HZ_BR_RESOLVE: begin
        ID_Control_NOP = 1'b1;
        PC_Write_En    = 1'b1;
        if (Branch_Taken_MEM) begin
          IF_ID_Write_En = 1'b0;
          IF_ID_Flush    = 1'b1;
        end else begin
          IF_ID_Write_En = 1'b1;
          IF_ID_Flush    = 1'b0;
        end
        state_d = HZ_IDLE;
      end
      default: begin
        if (lu) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
          ID_Control_NOP = 1'b1;
          state_d        = HZ_IDLE;
        end else if (Opcode_ID == OP_BEQ) begin
          PC_Write_En    = 1'b0;
          IF_ID_Write_En = 1'b0;
          IF_ID_Flush    = 1'b1;
          if (BRANCH_RESOLVE_STAGES == 1) begin
            state_d = HZ_BR_RESOLVE;
          end else begin
            state_d = HZ_BR_WAIT;
            wait_d  = WAIT_INIT;
          end
        end else if (Opcode_ID == OP_JUMP) begin
          IF_ID_Write_En = 1'b0;
          IF_ID_Flush    = 1'b1;
          state_d        = HZ_IDLE;
        end else begin
          state_d = HZ_IDLE;
        end
      end
    endcase

    if (Reset) begin
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      IF_ID_Flush    = 1'b1;
      ID_Control_NOP = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_d = stall_q;
    if (!PC_Write_En && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  assign Hazard_State = state_q;
  assign Stall_Count  = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
module tb_hazard_control_unit;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] JMP   = 6'h02;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode_ID;
  logic [4:0]  Rs_ID, Rt_ID, Rt_EX;
  logic        MemRead_EX, Branch_Taken_MEM;
  logic        pcw, we, fl, nop;
  logic [1:0]  st;
  logic [15:0] cnt;
  logic        pcw2, we2, fl2, nop2;
  logic [1:0]  st2;
  logic [2:0]  cnt2;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hazard_control_unit #(.BRANCH_RESOLVE_STAGES(2), .STALL_CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode_ID(Opcode_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Branch_Taken_MEM(Branch_Taken_MEM),
    .PC_Write_En(pcw), .IF_ID_Write_En(we), .IF_ID_Flush(fl), .ID_Control_NOP(nop),
    .Hazard_State(st), .Stall_Count(cnt)
  );

  // Narrow counter instance used to reach saturation quickly.
  hazard_control_unit #(.BRANCH_RESOLVE_STAGES(2), .STALL_CNT_W(3)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Opcode_ID(Opcode_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Branch_Taken_MEM(Branch_Taken_MEM),
    .PC_Write_En(pcw2), .IF_ID_Write_En(we2), .IF_ID_Flush(fl2), .ID_Control_NOP(nop2),
    .Hazard_State(st2), .Stall_Count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Check the four control outputs in one call.
  task automatic ctl(input string tag, input logic p, input logic w, input logic f, input logic n);
    #1;
    chk({tag, ".pcw"},   {31'd0, pcw}, {31'd0, p});
    chk({tag, ".we"},    {31'd0, we},  {31'd0, w});
    chk({tag, ".flush"}, {31'd0, fl},  {31'd0, f});
    chk({tag, ".nop"},   {31'd0, nop}, {31'd0, n});
  endtask

  initial begin
    Reset = 1'b1; Opcode_ID = RTYPE; Rs_ID = 5'd1; Rt_ID = 5'd2;
    MemRead_EX = 1'b0; Rt_EX = 5'd0; Branch_Taken_MEM = 1'b0;

    // 1: reset for three cycles, then release with RTYPE in ID
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("rst.state", 32'(st), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    Reset = 1'b0;
    ctl("norm", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("norm.cnt", 32'(cnt), 32'd0);
    chk("norm.state", 32'(st), 32'd0);

    // 2: load-use on rs costs one stall cycle
    MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5; Rt_ID = 5'd9;
    ctl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lu.cnt", 32'(cnt), 32'd1);
    chk("lu.state", 32'(st), 32'd0);
    MemRead_EX = 1'b0;
    ctl("lu.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: cases that must not stall, and rt-only matches that must
    MemRead_EX = 1'b1; Rt_EX = 5'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
    ctl("lu.r0", 1'b1, 1'b1, 1'b0, 1'b0);
    Rt_EX = 5'd7; Opcode_ID = LW; Rt_ID = 5'd7; Rs_ID = 5'd3;
    ctl("lu.lwrt", 1'b1, 1'b1, 1'b0, 1'b0);
    Opcode_ID = SW;
    ctl("lu.swrt", 1'b0, 1'b0, 1'b0, 1'b1);
    Opcode_ID = JMP;
    ctl("lu.jrt", 1'b1, 1'b0, 1'b1, 1'b0);
    Rs_ID = 5'd7;
    ctl("lu.jrs", 1'b0, 1'b0, 1'b0, 1'b1);
    Opcode_ID = BEQ;
    ctl("lu.beq", 1'b0, 1'b0, 1'b0, 1'b1);
    MemRead_EX = 1'b0; Opcode_ID = RTYPE; Rs_ID = 5'd1; Rt_ID = 5'd2;

    // 4: BEQ taken: states 0,1,2,0 with two stall cycles
    Opcode_ID = BEQ; Branch_Taken_MEM = 1'b1;
    ctl("beqT.s0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    Opcode_ID = RTYPE;
    chk("beqT.st1", 32'(st), 32'd1);
    ctl("beqT.s1", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("beqT.st2", 32'(st), 32'd2);
    ctl("beqT.s2", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("beqT.st0", 32'(st), 32'd0);
    chk("beqT.cnt", 32'(cnt), 32'd3);

    // 5: BEQ not taken; taken pulse and LU inputs during wait are ignored
    Opcode_ID = BEQ; Branch_Taken_MEM = 1'b0;
    ctl("beqN.s0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    Opcode_ID = RTYPE; Branch_Taken_MEM = 1'b1;
    MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
    chk("beqN.st1", 32'(st), 32'd1);
    ctl("beqN.s1", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    Branch_Taken_MEM = 1'b0;
    chk("beqN.st2", 32'(st), 32'd2);
    ctl("beqN.s2", 1'b1, 1'b1, 1'b0, 1'b1);
    MemRead_EX = 1'b0; Rs_ID = 5'd1;
    tick();
    chk("beqN.st0", 32'(st), 32'd0);
    chk("beqN.cnt", 32'(cnt), 32'd5);

    // 6: jump flushes fetch for one cycle without stalling
    Opcode_ID = JMP;
    ctl("jmp", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    Opcode_ID = RTYPE;
    chk("jmp.cnt", 32'(cnt), 32'd5);
    ctl("jmp.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during BR_WAIT aborts the branch
    Opcode_ID = BEQ;
    tick();
    Opcode_ID = RTYPE;
    chk("rstw.st1", 32'(st), 32'd1);
    Reset = 1'b1; Branch_Taken_MEM = 1'b1;
    ctl("rstw.rst", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    Reset = 1'b0; Branch_Taken_MEM = 1'b0;
    chk("rstw.st", 32'(st), 32'd0);
    chk("rstw.cnt", 32'(cnt), 32'd0);
    chk("rstw.cnt2", 32'(cnt2), 32'd0);
    ctl("rstw.norm", 1'b1, 1'b1, 1'b0, 1'b0);

    // Held load-use: wide counter climbs, 3-bit counter saturates at 7
    MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
    for (int unsigned i = 0; i < 10; i++) tick();
    chk("sat.cnt", 32'(cnt), 32'd10);
    chk("sat.cnt2", 32'(cnt2), 32'd7);
    MemRead_EX = 1'b0;
    tick();
    chk("sat.hold", 32'(cnt2), 32'd7);
    chk("sat.pcw2", {31'd0, pcw2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case the clocking or stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
